spi_param_receiver: RTL and testbench

- Generalised MCU-to-FPGA control-word receiver, the successor to the fixed 7×16-bit ADC/SPI packet input.
- Runs off the system clock and oversamples an SPI-mode-0 slave link (SCK, MOSI, CS). It assembles a parametrised number of words and double-buffers them.
- Commits a complete frame atomically to the synthesis core (frequency, harmonic scale/initial, freq scale, harmonic count) only when the frame is valid.

---
 rtl/spi_param_pkg.sv | 26 ++
 rtl/spi_edge_sync.sv | 34 +++
 rtl/spi_param_receiver.sv | 161 ++++++++++++++++
 tb/tb_spi_param_receiver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_param_pkg.sv
// Shared types and constants for the SPI control-word receiver.
// The optional checksum word is controlled by SPI_PARAM_CHECKSUM_EN.
`timescale 1ns/1ps
package spi_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Default meaning of each payload word inside the committed bank
    localparam int SLOT_FREQ    = 0;
    localparam int SLOT_HSCALE0 = 1;
    localparam int SLOT_SINIT0  = 2;
    localparam int SLOT_HSCALE1 = 3;
    localparam int SLOT_SINIT1  = 4;
    localparam int SLOT_FSCALE  = 5;
    localparam int SLOT_HCOUNT  = 6;

    // Wide enough to count one word past the frame, so overflow is detectable
    function automatic int idx_width(input int word_count);
        return $clog2(word_count + 2);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for one asynchronous input, with rise/fall detect
// on the synchronised level.
`timescale 1ns/1ps
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_q[STAGES-1] & ~prev_q;
    assign fall     = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_param_receiver.sv
// SPI mode-0 slave that assembles a frame of control words into a shadow bank
// and commits it atomically. Define SPI_PARAM_CHECKSUM_EN for a trailing sum word.
`timescale 1ns/1ps
module spi_param_receiver
    import spi_param_pkg::*;
#(
    parameter int WORD_WIDTH  = 16,
    parameter int WORD_COUNT  = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             i_Clock,
    input  logic                             reset,
    input  logic                             i_SPI_Clock,
    input  logic                             i_SPI_Data,
    input  logic                             i_SPI_CS,
    output logic [WORD_WIDTH*WORD_COUNT-1:0] o_Words,
    output logic                             o_Valid,
    output logic                             o_Error,
    output logic                             o_Busy
);

`ifdef SPI_PARAM_CHECKSUM_EN
    localparam int FRAME_WORDS = WORD_COUNT + 1;
`else
    localparam int FRAME_WORDS = WORD_COUNT;
`endif
    localparam int IDX_W = idx_width(FRAME_WORDS);
    localparam int BIT_W = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;

    localparam logic [IDX_W-1:0] IDX_PAYLOAD = IDX_W'(WORD_COUNT);
    localparam logic [IDX_W-1:0] IDX_FULL    = IDX_W'(FRAME_WORDS);
    localparam logic [IDX_W-1:0] IDX_SAT     = IDX_W'(FRAME_WORDS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(WORD_WIDTH - 1);

    logic sck_level_unused, sck_rise, sck_fall_unused;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(i_Clock), .reset(reset), .async_in(i_SPI_Clock),
        .sync_out(sck_level_unused), .rise(sck_rise), .fall(sck_fall_unused)
    );

    // CS idles high, so its chain resets high to avoid a false fall after reset
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(i_Clock), .reset(reset), .async_in(i_SPI_CS),
        .sync_out(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(i_Clock), .reset(reset), .async_in(i_SPI_Data),
        .sync_out(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign o_Busy = ~cs_sync;

    state_t                           state_q, next_state;
    logic   [WORD_WIDTH-2:0]          shift_q;
    logic   [BIT_W-1:0]               bit_cnt_q;
    logic   [IDX_W-1:0]               word_idx_q;
    logic                             overflow_q;
    logic   [WORD_WIDTH*WORD_COUNT-1:0] shadow_q;
    logic   [WORD_WIDTH-1:0]          word_next;
    logic                             start_frame, shift_en, commit, reject, frame_ok;
`ifdef SPI_PARAM_CHECKSUM_EN
    logic   [WORD_WIDTH-1:0]          csum_acc_q;
    logic                             csum_ok_q;
`endif

    assign word_next = {shift_q, mosi_sync};

`ifdef SPI_PARAM_CHECKSUM_EN
    assign frame_ok = (word_idx_q == IDX_FULL) && (bit_cnt_q == '0) && !overflow_q && csum_ok_q;
`else
    assign frame_ok = (word_idx_q == IDX_FULL) && (bit_cnt_q == '0) && !overflow_q;
`endif

    always_ff @(posedge i_Clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state_q;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        commit      = 1'b0;
        reject      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    next_state  = ST_RECV;
                    start_frame = 1'b1;
                end
            end
            ST_RECV: begin
                // A CS rise wins over a coincident SCK rise
                if (cs_rise)       next_state = ST_CHECK;
                else if (sck_rise) shift_en   = 1'b1;
            end
            ST_CHECK: begin
                commit     = frame_ok;
                reject     = !frame_ok;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: the shadow bank is reset explicitly so an aborted frame can never leak old words.
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            o_Words    <= '0;
            o_Valid    <= 1'b0;
            o_Error    <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
            overflow_q <= 1'b0;
            shadow_q   <= '0;
`ifdef SPI_PARAM_CHECKSUM_EN
            csum_acc_q <= '0;
            csum_ok_q  <= 1'b0;
`endif
        end else begin
            o_Valid <= commit;
            o_Error <= reject;
            if (commit) o_Words <= shadow_q;

            if (start_frame) begin
                bit_cnt_q  <= '0;
                word_idx_q <= '0;
                overflow_q <= 1'b0;
`ifdef SPI_PARAM_CHECKSUM_EN
                csum_acc_q <= '0;
                csum_ok_q  <= 1'b0;
`endif
            end else if (shift_en) begin
                shift_q <= word_next[WORD_WIDTH-2:0];
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_q <= '0;
                    if (word_idx_q < IDX_PAYLOAD)
                        shadow_q[int'(word_idx_q)*WORD_WIDTH +: WORD_WIDTH] <= word_next;
                    // Index stops one past the frame; any word beyond that is an overflow
                    if (word_idx_q >= IDX_FULL) overflow_q <= 1'b1;
                    if (word_idx_q != IDX_SAT)  word_idx_q <= word_idx_q + IDX_W'(1);
`ifdef SPI_PARAM_CHECKSUM_EN
                    if (word_idx_q < IDX_PAYLOAD)
                        csum_acc_q <= csum_acc_q + word_next;
                    else if (word_idx_q == IDX_PAYLOAD)
                        csum_ok_q <= (word_next == csum_acc_q);
`endif
                end else begin
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_param_receiver.sv
// Directed bench for spi_param_receiver: valid commit, short/long/partial frames,
// CS glitch, reset mid-frame, idle SCK, and (with SPI_PARAM_CHECKSUM_EN) checksum frames.
`timescale 1ns/1ps
module tb_spi_param_receiver;
    import spi_param_pkg::*;

    localparam int  W         = 16;
    localparam int  N         = 7;
    localparam int  SYNC      = 2;
`ifdef SPI_PARAM_CHECKSUM_EN
    localparam int  FRAME_LEN = N + 1;
`else
    localparam int  FRAME_LEN = N;
`endif
    localparam real CLK_HALF  = 10.417;
    localparam real SPI_HALF  = 375.0;

    localparam logic [W*N-1:0] EXP_A = {16'h0032, 16'h0000, 16'h0500, 16'h0020,
                                        16'h01FA, 16'h0067, 16'h007B};
    localparam logic [W*N-1:0] EXP_B = {16'h0F0F, 16'h5A5A, 16'h8000, 16'hFFFF,
                                        16'h0001, 16'hABCD, 16'h1234};

    logic clk = 1'b0, reset = 1'b1, sck = 1'b0, mosi = 1'b0, cs = 1'b1;
    logic [W*N-1:0] o_words;
    logic o_valid, o_error, o_busy;

    int checks = 0, errors = 0, valid_cnt = 0, error_cnt = 0;
    int v0, e0, lat;
    logic [W-1:0] frame [0:9];

    spi_param_receiver #(.WORD_WIDTH(W), .WORD_COUNT(N), .SYNC_STAGES(SYNC)) dut (
        .i_Clock(clk), .reset(reset), .i_SPI_Clock(sck), .i_SPI_Data(mosi),
        .i_SPI_CS(cs), .o_Words(o_words), .o_Valid(o_valid), .o_Error(o_error),
        .o_Busy(o_busy)
    );

    always #(CLK_HALF) clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) valid_cnt++;
        if (o_error) error_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload from a packed bank; checksum (if enabled) is the mod-2^W sum of the payload
    task automatic load_frame(input logic [W*N-1:0] bank, input logic [W-1:0] extra);
        logic [W-1:0] sum;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            frame[i] = bank[i*W +: W];
            sum      = sum + bank[i*W +: W];
        end
`ifdef SPI_PARAM_CHECKSUM_EN
        frame[N] = sum;
`endif
        frame[FRAME_LEN] = extra;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int b = W - 1; b >= W - n; b--) begin
            mosi = w[b];
            #(SPI_HALF) sck = 1'b1;
            #(SPI_HALF) sck = 1'b0;
        end
    endtask

    task automatic send_body(input int nwords, input int extra_bits);
        cs = 1'b0;
        #(SPI_HALF);
        for (int i = 0; i < nwords; i++) send_bits(frame[i], W);
        if (extra_bits > 0) send_bits(frame[nwords], extra_bits);
        #(SPI_HALF);
    endtask

    // Raise CS just after a falling clock edge and report the cycle o_Valid appears
    task automatic end_frame(output int latency);
        latency = -1;
        @(negedge clk);
        cs = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (o_valid && latency < 0) latency = k;
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        // Reset and idle
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1000;
        check("reset_words", o_words, '0);
        check("reset_busy", o_busy, 1'b0);
        check("reset_valid_cnt", valid_cnt, 0);
        check("reset_error_cnt", error_cnt, 0);

        // Valid frame A
        load_frame(EXP_A, 16'hC3C3);
        v0 = valid_cnt; e0 = error_cnt;
        send_body(FRAME_LEN, 0);
        check("busy_in_frame", o_busy, 1'b1);
        end_frame(lat);
        check("valid_latency", lat, SYNC + 2);
        check("a_valid_pulse", valid_cnt - v0, 1);
        check("a_no_error", error_cnt - e0, 0);
        check("a_words", o_words, EXP_A);
        check("a_slot_freq", o_words[SLOT_FREQ*W +: W], 16'h007B);
        check("a_slot_hscale0", o_words[SLOT_HSCALE0*W +: W], 16'h0067);
        check("a_slot_hcount", o_words[SLOT_HCOUNT*W +: W], 16'h0032);
        check("a_busy_after", o_busy, 1'b0);

        // Short frame (one payload word missing)
        load_frame(EXP_B, 16'hC3C3);
        v0 = valid_cnt; e0 = error_cnt;
        send_body(FRAME_LEN - 1, 0);
        end_frame(lat);
        check("short_error", error_cnt - e0, 1);
        check("short_no_valid", valid_cnt - v0, 0);
        check("short_words_kept", o_words, EXP_A);

        // Full frame plus 5 stray bits
        v0 = valid_cnt; e0 = error_cnt;
        send_body(FRAME_LEN, 5);
        end_frame(lat);
        check("partial_error", error_cnt - e0, 1);
        check("partial_no_valid", valid_cnt - v0, 0);
        check("partial_words_kept", o_words, EXP_A);

        // One word too many
        v0 = valid_cnt; e0 = error_cnt;
        send_body(FRAME_LEN + 1, 0);
        end_frame(lat);
        check("long_error", error_cnt - e0, 1);
        check("long_no_valid", valid_cnt - v0, 0);
        check("long_words_kept", o_words, EXP_A);

        // CS glitch with no bits
        v0 = valid_cnt; e0 = error_cnt;
        cs = 1'b0;
        #(SPI_HALF);
        end_frame(lat);
        check("glitch_error", error_cnt - e0, 1);
        check("glitch_no_valid", valid_cnt - v0, 0);

        // Reset in the middle of word 3, then a clean frame B
        v0 = valid_cnt; e0 = error_cnt;
        send_body(2, 5);
        reset = 1'b1;
        cs    = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #500;
        check("midreset_words", o_words, '0);
        check("midreset_busy", o_busy, 1'b0);
        check("midreset_no_pulses", (valid_cnt - v0) + (error_cnt - e0), 0);
        send_body(FRAME_LEN, 0);
        end_frame(lat);
        check("b_valid_pulse", valid_cnt - v0, 1);
        check("b_no_error", error_cnt - e0, 0);
        check("b_words", o_words, EXP_B);

        // SCK activity while CS is high
        v0 = valid_cnt; e0 = error_cnt;
        send_bits(16'hA5A5, W);
        repeat (8) @(negedge clk);
        check("idle_sck_no_pulses", (valid_cnt - v0) + (error_cnt - e0), 0);
        check("idle_sck_words", o_words, EXP_B);
        check("idle_sck_busy", o_busy, 1'b0);

`ifdef SPI_PARAM_CHECKSUM_EN
        // Corrupted checksum, then the correct one
        load_frame(EXP_A, 16'hC3C3);
        frame[N] = frame[N] ^ 16'h0001;
        v0 = valid_cnt; e0 = error_cnt;
        send_body(FRAME_LEN, 0);
        end_frame(lat);
        check("csum_bad_error", error_cnt - e0, 1);
        check("csum_bad_no_valid", valid_cnt - v0, 0);
        check("csum_bad_words_kept", o_words, EXP_B);
        load_frame(EXP_A, 16'hC3C3);
        v0 = valid_cnt; e0 = error_cnt;
        send_body(FRAME_LEN, 0);
        end_frame(lat);
        check("csum_good_valid", valid_cnt - v0, 1);
        check("csum_good_words", o_words, EXP_A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
